// File: rtl/rs_issue_arbiter_pkg.sv
// Shared definitions for the RS issue arbiter.
//   N_REQ_DEF : default number of requesting reservation-station entries
//   N_FU_DEF  : default number of grant slots / FU ports
//   rs_idx_t  : entry index type for the default configuration
package rs_issue_arbiter_pkg;

  localparam int unsigned N_REQ_DEF = 16;
  localparam int unsigned N_FU_DEF  = 2;
  localparam int unsigned IDX_W_DEF = $clog2(N_REQ_DEF);

  typedef logic [IDX_W_DEF-1:0] rs_idx_t;

endpackage

// File: rtl/rs_issue_arbiter_rr_pick.sv
// Round-robin single pick: returns the first set bit of eligible, searching
// upward from start and wrapping modulo N.
//   eligible : candidate vector
//   start    : highest-priority index
//   pick     : one-hot of the chosen index (zero if none)
//   idx      : encoded chosen index (zero if none)
//   found    : at least one candidate was eligible
module rs_issue_arbiter_rr_pick
  import rs_issue_arbiter_pkg::*;
#(
  parameter int unsigned N = N_REQ_DEF,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] start,
  output logic [N-1:0] pick,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  always_comb begin
    // Rotate right so that bit 0 of rot corresponds to index start.
    rot   = N'({eligible, eligible} >> start);
    found = 1'b0;
    off   = '0;
    // Descending scan leaves the lowest set bit in off.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = W'(i);
      end
    end
    // Rotate back; W-bit addition wraps because N is a power of two.
    idx  = found ? W'(off + start) : '0;
    pick = found ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/rs_issue_arbiter.sv
// Round-robin issue scheduler: fills free FU grant slots with ready RS
// entries, searching from a rotating pointer; grants are registered and held
// under FU backpressure.
//   clock, reset : clock and synchronous active-high reset
//   squash       : flush all held grants, no loads this cycle
//   req          : per-entry ready-to-issue
//   fu_ready     : per-slot FU accepts the held grant
//   gnt_valid    : per-slot grant valid
//   gnt_idx      : per-slot entry index, slot s at [s*IDX_W +: IDX_W]
//   gnt_onehot   : OR of one-hot indices over valid slots
//   rr_ptr       : current round-robin start index
module rs_issue_arbiter
  import rs_issue_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = N_REQ_DEF,
  parameter  int unsigned N_FU  = N_FU_DEF,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  squash,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_FU-1:0]       fu_ready,
  output logic [N_FU-1:0]       gnt_valid,
  output logic [N_FU*IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0]      gnt_onehot,
  output logic [IDX_W-1:0]      rr_ptr
);

  logic [N_FU-1:0]             valid_q, valid_d;
  logic [N_FU-1:0][IDX_W-1:0]  idx_q, idx_d;
  logic [N_REQ-1:0]            onehot_q, onehot_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;

  logic [N_FU-1:0]             free;
  logic [N_FU-1:0]             found_vec;
  logic [N_FU-1:0][IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]            base_elig;

  // Every valid slot, held or accepted, blocks its index from regrant.
  assign free      = ~valid_q | fu_ready;
  assign base_elig = req & ~onehot_q;

  for (genvar s = 0; s < N_FU; s++) begin : g_slot
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;

    if (s == 0) begin : g_first
      assign elig = base_elig;
    end else begin : g_next
      // Only a slot that actually loads consumes its pick.
      assign elig = g_slot[s-1].elig & ~(free[s-1] ? g_slot[s-1].pick : '0);
    end

    rs_issue_arbiter_rr_pick #(
      .N (N_REQ),
      .W (IDX_W)
    ) u_pick (
      .eligible (elig),
      .start    (ptr_q),
      .pick     (pick),
      .idx      (idx),
      .found    (found)
    );

    assign found_vec[s] = found;
    assign pick_idx[s]  = idx;
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (squash) begin
      valid_d = '0;
      idx_d   = '0;
    end else begin
      for (int s = 0; s < N_FU; s++) begin
        if (free[s]) begin
          valid_d[s] = found_vec[s];
          idx_d[s]   = found_vec[s] ? pick_idx[s] : '0;
          // Ascending loop: the highest-numbered loading slot wins.
          if (found_vec[s]) begin
            ptr_d = pick_idx[s] + IDX_W'(1);
          end
        end
      end
    end
    onehot_d = '0;
    for (int s = 0; s < N_FU; s++) begin
      if (valid_d[s]) begin
        onehot_d[idx_d[s]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q  <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt_valid  = valid_q;
  assign gnt_idx    = idx_q;
  assign gnt_onehot = onehot_q;
  assign rr_ptr     = ptr_q;

endmodule
